// File: rtl/lru_ctrl_if.sv
// -----------------------------------------------------------------------------
// lru_ctrl_if
// Bundles the request/response handshakes and the LRU regfile port of
// lru_ctrl into one interface.
//
//   slave  modport : the LRU controller itself (lru_ctrl).
//   master modport : the surrounding environment. It drives the hit, fill and
//                    victim-lookup requests, and it owns the regfile, which
//                    returns rf_q combinationally for rf_ra.
//
// Signals:
//   hit_valid/hit_idx/hit_way/hit_ready    one-hot hit update request
//   fill_valid/fill_idx/fill_way/fill_ready one-hot fill update request
//   vic_valid/vic_idx/vic_ready            victim-way lookup request
//   vic_rsp_valid/vic_rsp_way              registered lookup response
//   rf_ra/rf_wa/rf_wr/rf_wd/rf_q           LRU regfile port
//   init_done                              initialisation sweep finished
// -----------------------------------------------------------------------------
interface lru_ctrl_if #(
  parameter int AW = 13
);
  logic          hit_valid;
  logic [AW-1:0] hit_idx;
  logic [3:0]    hit_way;
  logic          hit_ready;

  logic          fill_valid;
  logic [AW-1:0] fill_idx;
  logic [3:0]    fill_way;
  logic          fill_ready;

  logic          vic_valid;
  logic [AW-1:0] vic_idx;
  logic          vic_ready;
  logic          vic_rsp_valid;
  logic [1:0]    vic_rsp_way;

  logic [AW-1:0] rf_ra;
  logic [AW-1:0] rf_wa;
  logic          rf_wr;
  logic [2:0]    rf_wd;
  logic [2:0]    rf_q;

  logic          init_done;

  modport master (
    output hit_valid, hit_idx, hit_way,
    output fill_valid, fill_idx, fill_way,
    output vic_valid, vic_idx,
    output rf_q,
    input  hit_ready, fill_ready, vic_ready,
    input  vic_rsp_valid, vic_rsp_way,
    input  rf_ra, rf_wa, rf_wr, rf_wd,
    input  init_done
  );

  modport slave (
    input  hit_valid, hit_idx, hit_way,
    input  fill_valid, fill_idx, fill_way,
    input  vic_valid, vic_idx,
    input  rf_q,
    output hit_ready, fill_ready, vic_ready,
    output vic_rsp_valid, vic_rsp_way,
    output rf_ra, rf_wa, rf_wr, rf_wd,
    output init_done
  );
endinterface

// File: rtl/lru_ctrl.sv
// -----------------------------------------------------------------------------
// lru_ctrl
// Pseudo-LRU (3-bit tree) controller for a 4-way set-associative cache.
// The LRU bits of every set live in an external regfile with a
// combinational read port (rf_q for rf_ra) and a synchronous write port.
//
// After reset the block sweeps all ENTRIES sets, writing 3'b000 to each,
// then raises init_done and starts serving one request per cycle:
//   fill / hit : read-modify-write of the tree bits for the touched way
//   vic        : read the tree bits and return the victim way one cycle later
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset (restarts the sweep)
//   bus    lru_ctrl_if.slave: request handshakes, lookup response, regfile
//
// Configuration macro:
//   LRU_CTRL_RR_ARB_EN  defined   -> round-robin arbitration over
//                                    fill, hit, vic (pointer resets to fill)
//                       undefined -> fixed priority fill > hit > vic
// -----------------------------------------------------------------------------
module lru_ctrl #(
  parameter int ENTRIES = 8192,
  parameter int AW      = 13
) (
  input logic       clk,
  input logic       reset,
  lru_ctrl_if.slave bus
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    GNT_FILL = 2'd0,
    GNT_HIT  = 2'd1,
    GNT_VIC  = 2'd2,
    GNT_NONE = 2'd3
  } gnt_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(ENTRIES - 1);

  // Lowest set bit of a way vector: {found, way index}.
  function automatic logic [2:0] way_sel(input logic [3:0] way);
    logic [2:0] res;
    if (way[0]) begin
      res = 3'b100;
    end else if (way[1]) begin
      res = 3'b101;
    end else if (way[2]) begin
      res = 3'b110;
    end else if (way[3]) begin
      res = 3'b111;
    end else begin
      res = 3'b000;
    end
    return res;
  endfunction

  // New tree bits after touching `way`: the root points away from the
  // touched half, the touched half's leaf points away from the touched way,
  // and the other half's leaf is preserved.
  function automatic logic [2:0] lru_update(input logic [1:0] way, input logic [2:0] q);
    logic [2:0] res;
    case (way)
      2'd0:    res = {1'b0, q[1], 1'b0};
      2'd1:    res = {1'b0, q[1], 1'b1};
      2'd2:    res = {1'b1, 1'b0, q[0]};
      2'd3:    res = {1'b1, 1'b1, q[0]};
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  // Follow the tree away from the recently used side to find the victim.
  function automatic logic [1:0] lru_victim(input logic [2:0] q);
    logic [1:0] res;
    case (q)
      3'b000, 3'b001: res = 2'd3;
      3'b010, 3'b011: res = 2'd2;
      3'b100, 3'b110: res = 2'd1;
      3'b101, 3'b111: res = 2'd0;
      default:        res = 2'd0;
    endcase
    return res;
  endfunction

  // First valid requester in the given order; v[2] belongs to `a`.
  function automatic gnt_e pick3(input logic [2:0] v, input gnt_e a, input gnt_e b,
                                 input gnt_e c);
    gnt_e res;
    if (v[2]) begin
      res = a;
    end else if (v[1]) begin
      res = b;
    end else if (v[0]) begin
      res = c;
    end else begin
      res = GNT_NONE;
    end
    return res;
  endfunction

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          init_done_q, init_done_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [1:0]    rsp_way_q, rsp_way_d;

  gnt_e          gnt_s;
  logic          hit_ready_s, fill_ready_s, vic_ready_s;
  logic [AW-1:0] rf_ra_s, rf_wa_s;
  logic          rf_wr_s;
  logic [2:0]    rf_wd_s;
  logic [AW-1:0] upd_idx_s;
  logic [2:0]    sel_s;

`ifdef LRU_CTRL_RR_ARB_EN
  gnt_e rr_q, rr_d;

  // Rotating priority: rr_q names the requester that is served first.
  always_comb begin
    case (rr_q)
      GNT_HIT: gnt_s = pick3({bus.hit_valid, bus.vic_valid, bus.fill_valid},
                             GNT_HIT, GNT_VIC, GNT_FILL);
      GNT_VIC: gnt_s = pick3({bus.vic_valid, bus.fill_valid, bus.hit_valid},
                             GNT_VIC, GNT_FILL, GNT_HIT);
      default: gnt_s = pick3({bus.fill_valid, bus.hit_valid, bus.vic_valid},
                             GNT_FILL, GNT_HIT, GNT_VIC);
    endcase
  end

  // After a grant the requester following the winner moves to the front.
  always_comb begin
    rr_d = rr_q;
    if (!reset && state_q == ST_RUN) begin
      case (gnt_s)
        GNT_FILL: rr_d = GNT_HIT;
        GNT_HIT:  rr_d = GNT_VIC;
        GNT_VIC:  rr_d = GNT_FILL;
        default:  rr_d = rr_q;
      endcase
    end else begin
      rr_d = rr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= GNT_FILL;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  // Fixed priority fill > hit > vic.
  always_comb begin
    gnt_s = pick3({bus.fill_valid, bus.hit_valid, bus.vic_valid},
                  GNT_FILL, GNT_HIT, GNT_VIC);
  end
`endif

  // Sweep / service sequencing, handshakes and regfile port control.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    init_done_d  = init_done_q;
    rsp_valid_d  = 1'b0;
    rsp_way_d    = rsp_way_q;
    hit_ready_s  = 1'b0;
    fill_ready_s = 1'b0;
    vic_ready_s  = 1'b0;
    rf_ra_s      = '0;
    rf_wa_s      = '0;
    rf_wr_s      = 1'b0;
    rf_wd_s      = 3'b000;
    upd_idx_s    = '0;
    sel_s        = 3'b000;

    if (reset) begin
      // Outputs stay quiet while reset is held; registers reload below.
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_INIT: begin
          rf_ra_s = cnt_q;
          rf_wa_s = cnt_q;
          rf_wr_s = 1'b1;
          rf_wd_s = 3'b000;
          if (cnt_q == LAST_IDX) begin
            // Last set written: the counter holds, it never wraps.
            state_d     = ST_RUN;
            init_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
        ST_RUN: begin
          case (gnt_s)
            GNT_FILL: begin
              fill_ready_s = 1'b1;
              upd_idx_s    = bus.fill_idx;
              sel_s        = way_sel(bus.fill_way);
            end
            GNT_HIT: begin
              hit_ready_s = 1'b1;
              upd_idx_s   = bus.hit_idx;
              sel_s       = way_sel(bus.hit_way);
            end
            GNT_VIC: begin
              vic_ready_s = 1'b1;
              rf_ra_s     = bus.vic_idx;
              rsp_valid_d = 1'b1;
              rsp_way_d   = lru_victim(bus.rf_q);
            end
            default: begin
              rsp_valid_d = 1'b0;
            end
          endcase
          if (gnt_s == GNT_FILL || gnt_s == GNT_HIT) begin
            // Read-modify-write in one cycle; an empty way vector is
            // accepted but leaves the entry untouched.
            rf_ra_s = upd_idx_s;
            rf_wa_s = upd_idx_s;
            rf_wr_s = sel_s[2];
            if (sel_s[2]) begin
              rf_wd_s = lru_update(sel_s[1:0], bus.rf_q);
            end else begin
              rf_wd_s = 3'b000;
            end
          end else begin
            rf_wr_s = 1'b0;
          end
        end
        default: begin
          state_d = ST_INIT;
        end
      endcase
    end
  end

  // State, sweep counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_way_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_way_q   <= rsp_way_d;
    end
  end

  assign bus.hit_ready     = hit_ready_s;
  assign bus.fill_ready    = fill_ready_s;
  assign bus.vic_ready     = vic_ready_s;
  assign bus.vic_rsp_valid = rsp_valid_q;
  assign bus.vic_rsp_way   = rsp_way_q;
  assign bus.rf_ra         = rf_ra_s;
  assign bus.rf_wa         = rf_wa_s;
  assign bus.rf_wr         = rf_wr_s;
  assign bus.rf_wd         = rf_wd_s;
  assign bus.init_done     = init_done_q;

endmodule

// File: tb/tb_lru_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lru_ctrl
// Self-checking bench for lru_ctrl. It owns the LRU regfile, drives directed
// and random requests, and compares the DUT every cycle against a
// behavioural model of the controller (sweep position, per-set tree bits,
// arbitration order, pending lookup response). Directed sequences add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_lru_ctrl;
  localparam int ENTRIES = 8192;
  localparam int AW      = 13;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lru_ctrl_if #(.AW(AW)) bus ();

  lru_ctrl #(.ENTRIES(ENTRIES), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Attached regfile: combinational read, write on the rising edge.
  logic [2:0] rf_mem [ENTRIES];
  assign bus.rf_q = rf_mem[bus.rf_ra];
  always @(posedge clk) begin
    if (bus.rf_wr) rf_mem[bus.rf_wa] <= bus.rf_wd;
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [2:0] m_mem [ENTRIES];
  int         m_cnt;
  bit         m_run, m_done, m_rsp_v, m_live;
  logic [1:0] m_rsp_way;
  int         m_rr;
  logic [1:0] vic_tbl [8] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd0, 2'd1, 2'd0};

  initial begin
    m_live = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_hit_ready", 32'(bus.hit_ready), 32'd0);
        chk("rst_fill_ready", 32'(bus.fill_ready), 32'd0);
        chk("rst_vic_ready", 32'(bus.vic_ready), 32'd0);
        chk("rst_rf_wr", 32'(bus.rf_wr), 32'd0);
        if (m_live) begin
          chk("init_done", 32'(bus.init_done), 32'(m_done));
          chk("vic_rsp_valid", 32'(bus.vic_rsp_valid), 32'(m_rsp_v));
          chk("vic_rsp_way", 32'(bus.vic_rsp_way), 32'(m_rsp_way));
        end
        m_live = 1'b1; m_run = 1'b0; m_cnt = 0; m_done = 1'b0;
        m_rsp_v = 1'b0; m_rsp_way = 2'd0; m_rr = 0;
      end else if (m_live) begin
        bit nxt_rsp_v;
        chk("init_done", 32'(bus.init_done), 32'(m_done));
        chk("vic_rsp_valid", 32'(bus.vic_rsp_valid), 32'(m_rsp_v));
        chk("vic_rsp_way", 32'(bus.vic_rsp_way), 32'(m_rsp_way));
        nxt_rsp_v = 1'b0;
        if (!m_run) begin
          chk("init_readies", 32'({bus.fill_ready, bus.hit_ready, bus.vic_ready}), 32'd0);
          chk("init_rf_wr", 32'(bus.rf_wr), 32'd1);
          chk("init_rf_wa", 32'(bus.rf_wa), 32'(m_cnt));
          chk("init_rf_ra", 32'(bus.rf_ra), 32'(m_cnt));
          chk("init_rf_wd", 32'(bus.rf_wd), 32'd0);
          m_mem[m_cnt] = 3'b000;
          m_cnt++;
          if (m_cnt == ENTRIES) begin
            m_run  = 1'b1;
            m_done = 1'b1;
          end
        end else begin
          bit v [3];
          int g;
          v[0] = bus.fill_valid; v[1] = bus.hit_valid; v[2] = bus.vic_valid;
          g = -1;
          for (int k = 0; k < 3; k++) begin
            int c;
`ifdef LRU_CTRL_RR_ARB_EN
            c = (m_rr + k) % 3;
`else
            c = k;
`endif
            if (g < 0 && v[c]) g = c;
          end
          chk("fill_ready", 32'(bus.fill_ready), 32'(g == 0));
          chk("hit_ready", 32'(bus.hit_ready), 32'(g == 1));
          chk("vic_ready", 32'(bus.vic_ready), 32'(g == 2));
          if (g == 0 || g == 1) begin
            logic [AW-1:0] idx;
            logic [3:0]    wv;
            int            w;
            logic [2:0]    q, upd;
            idx = (g == 0) ? bus.fill_idx : bus.hit_idx;
            wv  = (g == 0) ? bus.fill_way : bus.hit_way;
            w = -1;
            for (int i = 0; i < 4; i++) if (w < 0 && wv[i]) w = i;
            chk("upd_rf_ra", 32'(bus.rf_ra), 32'(idx));
            if (w < 0) begin
              chk("upd_rf_wr0", 32'(bus.rf_wr), 32'd0);
            end else begin
              q = m_mem[idx];
              if (w < 2) upd = {1'b0, q[1], w[0]};
              else       upd = {1'b1, w[0], q[0]};
              chk("upd_rf_wr", 32'(bus.rf_wr), 32'd1);
              chk("upd_rf_wa", 32'(bus.rf_wa), 32'(idx));
              chk("upd_rf_wd", 32'(bus.rf_wd), 32'(upd));
              m_mem[idx] = upd;
            end
          end else if (g == 2) begin
            chk("vic_rf_ra", 32'(bus.rf_ra), 32'(bus.vic_idx));
            chk("vic_rf_wr", 32'(bus.rf_wr), 32'd0);
            nxt_rsp_v = 1'b1;
            m_rsp_way = vic_tbl[m_mem[bus.vic_idx]];
          end else begin
            chk("idle_rf_wr", 32'(bus.rf_wr), 32'd0);
            chk("idle_rf_ra", 32'(bus.rf_ra), 32'd0);
            chk("idle_rf_wa", 32'(bus.rf_wa), 32'd0);
          end
          if (g >= 0) m_rr = (g + 1) % 3;
        end
        m_rsp_v = nxt_rsp_v;
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic set_idle();
    bus.hit_valid = 1'b0;  bus.hit_idx = '0;  bus.hit_way = 4'd0;
    bus.fill_valid = 1'b0; bus.fill_idx = '0; bus.fill_way = 4'd0;
    bus.vic_valid = 1'b0;  bus.vic_idx = '0;
  endtask

  // One cycle with a single request (0 fill, 1 hit, 2 vic, else idle);
  // returns at the negedge of that cycle.
  task automatic drive1(input int kind, input logic [AW-1:0] idx, input logic [3:0] way);
    @(posedge clk); #1;
    set_idle();
    case (kind)
      0: begin bus.fill_valid = 1'b1; bus.fill_idx = idx; bus.fill_way = way; end
      1: begin bus.hit_valid = 1'b1; bus.hit_idx = idx; bus.hit_way = way; end
      2: begin bus.vic_valid = 1'b1; bus.vic_idx = idx; end
      default: ;
    endcase
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    set_idle();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Counts sweep cycles until init_done rises, with a bounded wait.
  task automatic wait_init(input string tag);
    int  cyc, wr;
    bit  done;
    cyc = 0; wr = 0; done = 1'b0;
    while (!done && cyc < ENTRIES + 20) begin
      @(negedge clk);
      if (bus.init_done) done = 1'b1;
      else begin
        cyc++;
        if (bus.rf_wr) wr++;
      end
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_sweep_writes"}, 32'(wr), 32'(ENTRIES));
    chk({tag, "_sweep_cycles"}, 32'(cyc), 32'(ENTRIES));
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.fill_valid = ($urandom_range(0, 2) == 0);
      bus.hit_valid  = ($urandom_range(0, 1) == 0);
      bus.vic_valid  = ($urandom_range(0, 2) == 0);
      bus.fill_idx   = AW'($urandom_range(0, 15));
      bus.hit_idx    = AW'($urandom_range(0, 15));
      bus.vic_idx    = AW'($urandom_range(0, 15));
      bus.fill_way   = 4'($urandom_range(0, 15));
      bus.hit_way    = 4'($urandom_range(0, 15));
    end
    @(posedge clk); #1;
    set_idle();
  endtask

  initial begin
    bit found;
    set_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_init("init0");

    // Three simultaneous requesters: fill, then hit, then vic.
    @(posedge clk); #1;
    bus.fill_valid = 1'b1; bus.fill_idx = AW'(7);  bus.fill_way = 4'b0100;
    bus.hit_valid  = 1'b1; bus.hit_idx  = AW'(9);  bus.hit_way  = 4'b0001;
    bus.vic_valid  = 1'b1; bus.vic_idx  = AW'(11);
    @(negedge clk);
    chk("arb0_readies", 32'({bus.fill_ready, bus.hit_ready, bus.vic_ready}), 32'b100);
    chk("arb0_rf_wa", 32'(bus.rf_wa), 32'd7);
    chk("arb0_rf_wd", 32'(bus.rf_wd), 32'b100);
    @(posedge clk); #1 bus.fill_valid = 1'b0;
    @(negedge clk);
    chk("arb1_readies", 32'({bus.fill_ready, bus.hit_ready, bus.vic_ready}), 32'b010);
    chk("arb1_rf_wa", 32'(bus.rf_wa), 32'd9);
    chk("arb1_rf_wd", 32'(bus.rf_wd), 32'b000);
    @(posedge clk); #1 bus.hit_valid = 1'b0;
    @(negedge clk);
    chk("arb2_readies", 32'({bus.fill_ready, bus.hit_ready, bus.vic_ready}), 32'b001);
    chk("arb2_rf_ra", 32'(bus.rf_ra), 32'd11);
    drive1(3, '0, 4'd0);
    chk("arb2_rsp", 32'({bus.vic_rsp_valid, bus.vic_rsp_way}), 32'b111);

    // Hit way 1 on idx 5, then victim lookup.
    drive1(1, AW'(5), 4'b0010);
    chk("hit5_ready", 32'(bus.hit_ready), 32'd1);
    chk("hit5_rf_wa", 32'(bus.rf_wa), 32'd5);
    chk("hit5_rf_wd", 32'(bus.rf_wd), 32'b001);
    drive1(2, AW'(5), 4'd0);
    chk("vic5_ready", 32'(bus.vic_ready), 32'd1);
    drive1(3, '0, 4'd0);
    chk("vic5_rsp", 32'({bus.vic_rsp_valid, bus.vic_rsp_way}), 32'b111);

    // Back-to-back updates of idx 3.
    drive1(0, AW'(3), 4'b0001);
    chk("upd3a_rf_wd", 32'(bus.rf_wd), 32'b000);
    drive1(0, AW'(3), 4'b0100);
    chk("upd3b_rf_wd", 32'(bus.rf_wd), 32'b100);
    drive1(2, AW'(3), 4'd0);
    drive1(3, '0, 4'd0);
    chk("vic3_rsp", 32'({bus.vic_rsp_valid, bus.vic_rsp_way}), 32'b101);

    // Empty way vector: accepted, nothing written.
    drive1(1, AW'(10), 4'b0000);
    chk("hit10_ready", 32'(bus.hit_ready), 32'd1);
    chk("hit10_rf_wr", 32'(bus.rf_wr), 32'd0);
    drive1(2, AW'(10), 4'd0);
    drive1(3, '0, 4'd0);
    chk("vic10_rsp", 32'({bus.vic_rsp_valid, bus.vic_rsp_way}), 32'b111);
    chk("mem10", 32'(rf_mem[10]), 32'd0);

    // Non-one-hot way: lowest set bit (way 1) wins on idx 12 (000 -> 001).
    drive1(1, AW'(12), 4'b1010);
    chk("hit12_rf_wd", 32'(bus.rf_wd), 32'b001);

    random_run(2000);

    // Reset while running, then a reset in the middle of the sweep.
    do_reset();
    wait_init("init_run");
    drive1(2, AW'(7), 4'd0);
    drive1(3, '0, 4'd0);
    chk("vic7_after_reinit", 32'({bus.vic_rsp_valid, bus.vic_rsp_way}), 32'b111);

    do_reset();
    found = 1'b0;
    for (int i = 0; i < ENTRIES && !found; i++) begin
      @(negedge clk);
      if (bus.rf_wr && bus.rf_wa == AW'(3999)) found = 1'b1;
    end
    chk("mid_sweep_reached", 32'(found), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("mid_sweep_done_low", 32'(bus.init_done), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    wait_init("init_mid");

    random_run(300);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lru_ctrl.md
LRU_CTRL -- requirements
Module: lru_ctrl

Interface
REQ-001 Parameter ENTRIES, default 8192: number of LRU sets in the attached LRU regfile.
REQ-002 Parameter AW, default 13: index width; ENTRIES SHALL equal 2**AW.
REQ-003 clk  in  1: single clock; all state updates on its rising edge.
REQ-004 reset  in  1: synchronous, active-high reset.
REQ-005 hit_valid  in  1; hit_idx  in  AW; hit_way  in  4: one-hot hit update request.
REQ-006 hit_ready  out  1: hit request accepted this cycle.
REQ-007 fill_valid  in  1; fill_idx  in  AW; fill_way  in  4: one-hot fill update request.
REQ-008 fill_ready  out  1: fill request accepted this cycle.
REQ-009 vic_valid  in  1; vic_idx  in  AW: victim-way lookup request.
REQ-010 vic_ready  out  1: lookup accepted this cycle.
REQ-011 vic_rsp_valid  out  1; vic_rsp_way  out  2: registered lookup response.
REQ-012 rf_ra  out  AW; rf_wa  out  AW; rf_wr  out  1; rf_wd  out  3: regfile read index, write index, write enable, write data.
REQ-013 rf_q  in  3: regfile combinational read data at rf_ra.
REQ-014 init_done  out  1: high once the initialisation sweep has completed.

Function
REQ-015 States: INIT (sweep), RUN (service requests); the block SHALL enter INIT on reset.
REQ-016 INIT: 13-bit sweep counter starting at 0; each cycle rf_wa=rf_ra=counter, rf_wr=1, rf_wd=3'b000; counter increments by 1.
REQ-017 When the counter equals ENTRIES-1 and that write is issued, the next state SHALL be RUN and init_done SHALL go high the following cycle; the counter SHALL NOT wrap.
REQ-018 During INIT, hit_ready, fill_ready and vic_ready SHALL be 0.
REQ-019 RUN: exactly one grant per cycle; a ready is asserted only when the matching valid is high and that requester is granted.
REQ-020 Default arbitration is fixed priority fill > hit > vic.
REQ-021 Granted update (hit or fill) with index I and way W: rf_ra=rf_wa=I, rf_wr=1, all in the grant cycle; rf_wd is derived from rf_q.
REQ-022 Update rule: W=0 gives {0,q[1],0}; W=1 gives {0,q[1],1}; W=2 gives {1,0,q[0]}; W=3 gives {1,1,q[0]}.
REQ-023 Non-one-hot way: lowest set bit wins; way=0000 is accepted with rf_wr=0 (no write).
REQ-024 Granted lookup: rf_ra=vic_idx, rf_wr=0.
REQ-025 Decode rf_q to a way: 000/001 give 3; 010/011 give 2; 100/110 give 1; 101/111 give 0.
REQ-026 vic_rsp_valid and vic_rsp_way SHALL register the decoded way, valid exactly 1 cycle after the grant.
REQ-027 An update to index I in cycle N SHALL be visible to any access of I in cycle N+1; no bypass is needed.
REQ-028 Idle cycles (no valid): rf_wr=0, rf_ra=rf_wa=0.

Reset
REQ-029 Reset values: init_done=0, vic_rsp_valid=0, vic_rsp_way=0, sweep counter=0, all readies=0, rf_wr=0.
REQ-030 Reset asserted mid-sweep or in RUN SHALL restart INIT from index 0 on the cycle after reset deasserts; in-flight lookup responses are dropped.

Configuration
REQ-031 Macro LRU_CTRL_RR_ARB_EN defined: round-robin arbitration over fill, hit, vic; the last granted requester becomes lowest priority; the pointer resets to fill-first.
REQ-032 Macro undefined: fixed priority per REQ-020; no round-robin state is instantiated.

Verification
REQ-033 Reset for 1 cycle, then idle -> rf_wr=1 for exactly 8192 cycles with rf_wa 0..8191 and rf_wd=000; init_done=1 in cycle 8193; all readies stay 0 before that.
REQ-034 After init: hit idx=5, way=0010 -> rf_wa=5, rf_wd=001; then vic idx=5 -> vic_rsp_way=3 one cycle later.
REQ-035 fill(idx 7, way 0100), hit(idx 9) and vic all valid in the same cycle -> fixed mode grants fill (rf_wd=100 on idx 7), then hit, then vic on successive cycles; RR mode grants fill, hit, vic.
REQ-036 Update idx 3: way0 then way2 back-to-back -> writes 000 then 100; a lookup on idx 3 returns way 1.
REQ-037 Reset asserted at sweep index 4000 -> the sweep restarts at 0, init_done stays 0, and completes 8192 cycles after deassertion.
REQ-038 hit_way=0000 on idx 10 -> hit_ready=1, rf_wr=0, and the entry is unchanged.
